// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the multiply/divide unit: decodes MD instructions,
// issues one req/ready request at a time and stalls D while an MD op is pending.
// Optional watchdog enabled by defining MD_TIMEOUT_EN.
module md_issue_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_D,
    input  logic [31:0] instr_E,
    input  logic        valid_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        md_ready,
    input  logic        md_done,
    output logic        md_req,
    output logic [2:0]  md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        stall_D,
    output logic        busy,
    output logic        md_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_t      state_reg;
    logic        md_req_reg;
    logic [2:0]  md_op_reg;
    logic [31:0] md_a_reg;
    logic [31:0] md_b_reg;
    logic        timeout;

    // Returns {is_md_write, op} for an instruction word.
    function automatic logic [3:0] decode_write(input logic [31:0] ins);
        logic [3:0] res;
        res = 4'b0000;
        if (ins[31:26] == 6'h00) begin
            case (ins[5:0])
                6'h18:   res = {1'b1, 3'd0};
                6'h19:   res = {1'b1, 3'd1};
                6'h1A:   res = {1'b1, 3'd2};
                6'h1B:   res = {1'b1, 3'd3};
                6'h11:   res = {1'b1, 3'd4};
                6'h13:   res = {1'b1, 3'd5};
                default: res = 4'b0000;
            endcase
        end
        return res;
    endfunction

    function automatic logic is_md_class(input logic [31:0] ins);
        logic hit;
        hit = 1'b0;
        if (ins[31:26] == 6'h00) begin
            case (ins[5:0])
                6'h10, 6'h11, 6'h12, 6'h13,
                6'h18, 6'h19, 6'h1A, 6'h1B: hit = 1'b1;
                default:                    hit = 1'b0;
            endcase
        end
        return hit;
    endfunction

    logic [3:0] e_dec;
    logic       e_write;
    logic [2:0] e_op;
    logic       d_class;

    always_comb begin
        e_dec   = decode_write(instr_E);
        e_write = e_dec[3];
        e_op    = e_dec[2:0];
        d_class = is_md_class(instr_D);
    end

    // Only opcode and funct fields matter for decode.
    logic unused_fields;
    assign unused_fields = ^{instr_D[25:6], instr_E[25:6]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            md_req_reg <= 1'b0;
            md_op_reg  <= 3'd0;
            md_a_reg   <= 32'd0;
            md_b_reg   <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (valid_E && e_write) begin
                        state_reg  <= ST_REQ;
                        md_req_reg <= 1'b1;
                        md_op_reg  <= e_op;
                        md_a_reg   <= rs_E;
                        md_b_reg   <= e_op[2] ? 32'd0 : rt_E;
                    end
                end
                ST_REQ: begin
                    if (timeout) begin
                        state_reg  <= ST_IDLE;
                        md_req_reg <= 1'b0;
                    end else if (md_ready) begin
                        md_req_reg <= 1'b0;
                        // mthi/mtlo (op 4/5) complete on acceptance
                        state_reg  <= md_op_reg[2] ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (timeout || md_done) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    md_req_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef MD_TIMEOUT_EN
    logic [CNT_W-1:0] wd_cnt_reg;
    logic             md_err_reg;

    assign timeout = (state_reg != ST_IDLE) && (wd_cnt_reg == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_reg <= '0;
            md_err_reg <= 1'b0;
        end else begin
            // Held at zero in IDLE, so every REQ entry starts from a clean count.
            if (state_reg == ST_IDLE || timeout) begin
                wd_cnt_reg <= '0;
            end else begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end
            if (timeout) begin
                md_err_reg <= 1'b1;
            end
        end
    end

    assign md_err = md_err_reg;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_LAST;
    assign timeout = 1'b0;
    assign md_err  = 1'b0;
`endif

    assign md_req  = md_req_reg;
    assign md_op   = md_op_reg;
    assign md_a    = md_a_reg;
    assign md_b    = md_b_reg;
    assign busy    = (state_reg != ST_IDLE);
    assign stall_D = d_class && ((state_reg != ST_IDLE) || (valid_E && e_write));

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the outstanding MD operation.
module tb_md_issue_ctrl;

`ifdef MD_TIMEOUT_EN
    localparam int  TB_TIMEOUT = 8;
    localparam bit  TO_EN      = 1'b1;
`else
    localparam int  TB_TIMEOUT = 64;
    localparam bit  TO_EN      = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr_D = '0;
    logic [31:0] instr_E = '0;
    logic        valid_E = 1'b0;
    logic [31:0] rs_E = '0;
    logic [31:0] rt_E = '0;
    logic        md_ready = 1'b0;
    logic        md_done = 1'b0;
    logic        md_req;
    logic [2:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        stall_D;
    logic        busy;
    logic        md_err;

    md_issue_ctrl #(.TIMEOUT(TB_TIMEOUT), .CNT_W(7)) dut (
        .clk(clk), .reset(reset), .instr_D(instr_D), .instr_E(instr_E),
        .valid_E(valid_E), .rs_E(rs_E), .rt_E(rt_E), .md_ready(md_ready),
        .md_done(md_done), .md_req(md_req), .md_op(md_op), .md_a(md_a),
        .md_b(md_b), .stall_D(stall_D), .busy(busy), .md_err(md_err)
    );

    always #5 clk = ~clk;

    // Funct code for each md_op value (index = op).
    localparam logic [5:0] FUNCT [0:5] = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13};

    int n_vec = 0;
    int n_err = 0;

    // Model: one outstanding operation, either awaiting acceptance or awaiting done.
    bit          m_out;
    bit          m_acc;
    bit          m_err;
    int          m_age;
    logic [2:0]  m_op;
    logic [31:0] m_a;
    logic [31:0] m_b;

    // 0..5 = MD-write op code, 6 = mfhi/mflo, -1 = not an MD instruction.
    function automatic int md_kind(input logic [31:0] ins);
        if (ins[31:26] != 6'h00) return -1;
        for (int i = 0; i < 6; i++) begin
            if (ins[5:0] == FUNCT[i]) return i;
        end
        if (ins[5:0] == 6'h10 || ins[5:0] == 6'h12) return 6;
        return -1;
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] funct);
        logic [31:0] x;
        x = $urandom();
        x[31:26] = 6'h00;
        x[5:0] = funct;
        return x;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] x;
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return mk(FUNCT[r]);
        if (r == 6) return mk(6'h10);
        if (r == 7) return mk(6'h12);
        if (r == 8) return mk(6'h21);
        x = $urandom();
        x[31:26] = 6'h23;
        x[5:0] = FUNCT[$urandom_range(0, 5)];
        return x;
    endfunction

    task automatic model_clear();
        m_out = 0; m_acc = 0; m_err = 0; m_age = 0;
        m_op = '0; m_a = '0; m_b = '0;
    endtask

    task automatic model_edge();
        int k;
        if (!reset) begin
            model_clear();
        end else if (m_out) begin
            m_age++;
            if (TO_EN && m_age == TB_TIMEOUT) begin
                m_out = 0;
                m_err = 1;
            end else if (!m_acc) begin
                if (md_ready) begin
                    if (m_op >= 3'd4) m_out = 0;
                    else m_acc = 1;
                end
            end else if (md_done) begin
                m_out = 0;
            end
        end else begin
            k = md_kind(instr_E);
            if (valid_E && k >= 0 && k <= 5) begin
                m_out = 1; m_acc = 0; m_age = 0;
                m_op = 3'(k);
                m_a = rs_E;
                m_b = (k >= 4) ? 32'd0 : rt_E;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int kd;
        int ke;
        bit exp_stall;
        kd = md_kind(instr_D);
        ke = md_kind(instr_E);
        exp_stall = (kd >= 0) && (m_out || (valid_E && ke >= 0 && ke <= 5));
        check("md_req",  32'(md_req),  32'(m_out && !m_acc));
        check("busy",    32'(busy),    32'(m_out));
        check("stall_D", 32'(stall_D), 32'(exp_stall));
        check("md_err",  32'(md_err),  32'(m_err));
        check("md_op",   32'(md_op),   32'(m_op));
        check("md_a",    md_a,         m_a);
        check("md_b",    md_b,         m_b);
    endtask

    task automatic tick();
        #3;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        model_clear();
        tick();
        tick();
        reset = 1'b1;
        tick();

        // mult 7 * -3, accepted immediately
        instr_E = mk(6'h18); valid_E = 1; rs_E = 32'd7; rt_E = 32'hFFFF_FFFD; md_ready = 1;
        tick();
        valid_E = 0; instr_E = '0;
        tick();
        tick(); tick();
        md_done = 1; tick(); md_done = 0;
        tick(); tick();

        // div held off by md_ready=0 for 4 cycles, mflo waiting in D
        md_ready = 0; instr_E = mk(6'h1A); valid_E = 1; rs_E = 32'd100; rt_E = 32'd7;
        instr_D = mk(6'h12);
        tick();
        valid_E = 0;
        for (int i = 0; i < 4; i++) begin
            rs_E = $urandom(); rt_E = $urandom();
            tick();
        end
        md_ready = 1; tick();
        md_ready = 0; tick(); tick(); tick();
        md_done = 1; tick(); md_done = 0;
        tick();
        instr_D = '0;

        // mthi: one request cycle, operand B forced to zero, no done needed
        instr_E = mk(6'h11); valid_E = 1; rs_E = 32'h0000_1234; rt_E = 32'hDEAD_BEEF; md_ready = 1;
        tick();
        valid_E = 0;
        tick(); tick();

        // non-MD vs MD instruction in D while waiting
        instr_E = mk(6'h19); valid_E = 1; tick();
        valid_E = 0; tick();
        instr_D = mk(6'h21); tick();
        instr_D = mk(6'h10); tick();
        md_done = 1; tick(); md_done = 0;
        tick();
        instr_D = '0;

        // asynchronous reset in the middle of a divu
        instr_E = mk(6'h1B); valid_E = 1; tick();
        valid_E = 0; tick(); tick();
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check_all();
        @(posedge clk); #1;
        md_done = 1; tick();
        reset = 1'b1; tick();
        md_done = 0; tick();

`ifdef MD_TIMEOUT_EN
        // mult that never completes: watchdog fires and md_err sticks
        instr_E = mk(6'h18); valid_E = 1; md_ready = 1; instr_D = mk(6'h12); tick();
        valid_E = 0;
        for (int i = 0; i < TB_TIMEOUT + 4; i++) tick();
        instr_D = '0;
`endif

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            instr_D  = rand_instr();
            instr_E  = rand_instr();
            valid_E  = 1'($urandom_range(0, 1));
            rs_E     = $urandom();
            rt_E     = $urandom();
            md_ready = ($urandom_range(0, 2) == 0);
            md_done  = ($urandom_range(0, 3) == 0);
            tick();
        end
        md_done = 0; md_ready = 0; valid_E = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
